// File: rtl/pipe_shifter_if.sv
// ----------------------------------------------------------------------------
// pipe_shifter_if
// Handshake bundle for pipe_shifter.
//   in_valid / in_ready          : operation handshake (producer -> shifter)
//   in_data, in_shamt, in_op     : operand, shift amount, op select
//   in_tag                       : opaque sideband tag returned with result
//   out_valid / out_ready        : result handshake (shifter -> consumer)
//   out_data, out_tag            : result and its tag
// Modports: master = the environment driving operations and taking results,
//           slave  = the shifter itself.
// ----------------------------------------------------------------------------
interface pipe_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipe_shifter.sv
// ----------------------------------------------------------------------------
// pipe_shifter
// Fixed-latency pipelined barrel shifter: SLL / SRL / SRA / ROR.
// One register stage per shift-amount bit; stage k shifts by 2^k when that
// bit of the captured shift amount is set. Latency is $clog2(WIDTH) cycles;
// a single stall signal (result presented but not taken) freezes all stages.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears valids and the output regs)
//   bus  : pipe_shifter_if.slave (operation in, result out, valid/ready)
//
// Build option
//   PIPE_SHIFTER_ROTATE_EN : when defined, op 2'b11 rotates right; when not
//                            defined, op 2'b11 is a logical right shift and
//                            no wrap-around logic exists.
// ----------------------------------------------------------------------------
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    pipe_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = SHAMT_W - 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Stage registers. shamt/op are only needed by stages that still have a
    // shift to apply, so the final stage keeps just data, tag and valid.
    // The captured shift amount is shifted right each stage so that bit 0 is
    // always the control bit of the stage consuming it.
    logic [WIDTH-1:0]   data_p  [SHAMT_W];
    logic [TAG_W-1:0]   tag_p   [SHAMT_W];
    logic               vld_p   [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_p [SHAMT_W-1];
    logic [1:0]         op_p    [SHAMT_W-1];

    logic [WIDTH-1:0]   src_data  [SHAMT_W];
    logic [TAG_W-1:0]   src_tag   [SHAMT_W];
    logic               src_vld   [SHAMT_W];
    logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
    logic [1:0]         src_op    [SHAMT_W];
    logic [WIDTH-1:0]   nxt_data  [SHAMT_W];

    logic stall;

    // One fixed-distance shift step. SRA works stage by stage because the
    // MSB after a partial arithmetic shift is still the original sign bit;
    // ROR steps compose because each is a pure rotation.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input int unsigned      amt
    );
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0]        r;
        sd = d;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = sd >>> amt;
`ifdef PIPE_SHIFTER_ROTATE_EN
            default: r = (d >> amt) | (d << (WIDTH - amt));
`else
            default: r = d >> amt;
`endif
        endcase
        return r;
    endfunction

    assign stall        = vld_p[LAST] && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign bus.out_valid = vld_p[LAST];
    assign bus.out_data  = data_p[LAST];
    assign bus.out_tag   = tag_p[LAST];

    always_comb begin
        src_data[0]  = bus.in_data;
        src_tag[0]   = bus.in_tag;
        src_vld[0]   = bus.in_valid;
        src_shamt[0] = bus.in_shamt;
        src_op[0]    = bus.in_op;
        for (int k = 1; k < SHAMT_W; k++) begin
            src_data[k]  = data_p[k-1];
            src_tag[k]   = tag_p[k-1];
            src_vld[k]   = vld_p[k-1];
            src_shamt[k] = shamt_p[k-1];
            src_op[k]    = op_p[k-1];
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            nxt_data[k] = src_shamt[k][0] ? shift_stage(src_data[k], src_op[k], 1 << k)
                                          : src_data[k];
        end
    end

    // Stage boundary: valid bits (control, reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHAMT_W; k++) vld_p[k] <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) vld_p[k] <= src_vld[k];
        end
    end

    // Stage boundary: datapath. Only the output stage is cleared by reset so
    // the result port reads zero afterwards; reset wins over the load.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_p[k] <= nxt_data[k];
                tag_p[k]  <= src_tag[k];
            end
            for (int k = 0; k < LAST; k++) begin
                shamt_p[k] <= src_shamt[k] >> 1;
                op_p[k]    <= src_op[k];
            end
        end
        if (rst) begin
            data_p[LAST] <= '0;
            tag_p[LAST]  <= '0;
        end
    end
endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width; a power of two, at least 8.
REQ-002 The block SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-003 The block SHALL use a derived constant SHAMT_W = clog2(WIDTH), which is 5 for WIDTH=32.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  an operation is presented.
REQ-007 in_ready  output  1  the block accepts an operation this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SHAMT_W  shift amount.
REQ-010 in_op  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-011 in_tag  input  TAG_W  opaque tag returned with the result.
REQ-012 out_valid  output  1  a result is presented.
REQ-013 out_ready  input  1  the consumer accepts the result this cycle.
REQ-014 out_data  output  WIDTH  result.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 The pipeline SHALL have SHAMT_W register stages; stage k applies a shift of 2^k when in_shamt bit k is set, and passes data through otherwise.
REQ-017 An operation SHALL be accepted on a cycle where in_valid && in_ready.
REQ-018 With no stall, the result of an accepted operation SHALL appear with out_valid=1 exactly SHAMT_W cycles after acceptance (5 cycles for WIDTH=32).
REQ-019 stall SHALL be defined as out_valid && !out_ready; when stall=1 every stage SHALL hold its contents, and in_ready SHALL be 0.
REQ-020 in_ready SHALL equal !stall, computed combinationally.
REQ-021 The pipeline SHALL carry a valid bit per stage; bubbles SHALL advance and SHALL NOT be collapsed (fixed latency).
REQ-022 Results SHALL leave in acceptance order, with out_tag equal to the tag accepted with them.
REQ-023 While stalled, out_data and out_tag SHALL stay stable until the handshake completes.
REQ-024 SLL SHALL zero-fill on the right.
REQ-025 SRL SHALL zero-fill on the left.
REQ-026 SRA SHALL fill on the left with in_data[WIDTH-1].
REQ-027 ROR SHALL rotate right by in_shamt modulo WIDTH.
REQ-028 A shift amount of 0 SHALL return in_data unchanged for every op.
REQ-029 A shift amount of WIDTH-1 SHALL be handled exactly, e.g. SLL of 1 yields only the MSB set.
REQ-030 in_op and in_shamt SHALL be captured at acceptance; later input changes SHALL NOT affect in-flight operations.
REQ-031 An operation accepted on the same cycle a result leaves SHALL be lossless, sustaining throughput of 1 per cycle.

Reset
REQ-032 While rst=1 at a clock edge, all stage valid bits SHALL clear, out_valid=0, out_data=0 and out_tag=0.
REQ-033 Operations in flight when rst is asserted SHALL be discarded and SHALL never appear at the output.
REQ-034 On the cycle after reset, in_ready SHALL be 1.
REQ-035 rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-036 Macro PIPE_SHIFTER_ROTATE_EN defined: op 11 SHALL perform ROR as in REQ-027.
REQ-037 Macro PIPE_SHIFTER_ROTATE_EN undefined: op 11 SHALL behave exactly as SRL, and no rotate wrap logic SHALL be instantiated.
REQ-038 Latency and handshake behaviour SHALL be identical in both configurations.

Verification (WIDTH=32, TAG_W=4)
REQ-039 SLL in_data=0x00000001, shamt=31, tag=3 -> 5 cycles later out_valid=1, out_data=0x80000000, out_tag=3.
REQ-040 SRA 0x80000000 shamt=4 -> 0xF8000000; SRL 0x80000000 shamt=4 -> 0x08000000; results returned in order.
REQ-041 op=11 0x000000F1 shamt=4 -> 0x1000000F with PIPE_SHIFTER_ROTATE_EN defined; 0x0000000F without it.
REQ-042 Five back-to-back ops with tags 0..4, out_ready held 0 for 3 cycles once the first result appears -> in_ready=0 and out_data stable during the stall, then all five results delivered, tags in order 0..4, none lost or duplicated.
REQ-043 Three ops in flight, rst pulsed for 1 cycle -> out_valid=0 and in_ready=1 the next cycle, and none of the three results ever appears.
REQ-044 shamt=0 with each of the four ops on 0xA5A5A5A5 -> out_data=0xA5A5A5A5 for every op.
